axi_timer_irq: RTL and testbench

AXI4-lite slave combining a 32-bit down-counting timer with an interrupt pending/mask controller. It drives the 32-bit interrupt vector consumed by the mriscvcore `inirr` input, which is currently tied to zero. It attaches as an additional slave port of the system interconnect. It is word-addressed, consistent with the core's `addr>>2` address fix-up.

---
 rtl/axi_timer_irq_pkg.sv | 43 ++++
 rtl/irq_sync_edge.sv | 26 ++
 rtl/axi_timer_irq.sv | 191 +++++++++++++++++++
 tb/tb_axi_timer_irq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_timer_irq_pkg.sv
// Shared definitions for the AXI4-lite timer / interrupt controller slave:
// register offsets, CTRL bits, FSM state types and interconnect map entry.
package axi_timer_irq_pkg;

  localparam int ADDR_DEC_W = 3;

  localparam logic [ADDR_DEC_W-1:0] TIMER_CTRL  = 3'd0;
  localparam logic [ADDR_DEC_W-1:0] TIMER_LOAD  = 3'd1;
  localparam logic [ADDR_DEC_W-1:0] TIMER_COUNT = 3'd2;
  localparam logic [ADDR_DEC_W-1:0] TIMER_PEND  = 3'd3;
  localparam logic [ADDR_DEC_W-1:0] TIMER_MASK  = 3'd4;
  localparam logic [ADDR_DEC_W-1:0] TIMER_PRESC = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;

  // Interconnect memory-map entry (word addresses, 8-word window).
  localparam logic [31:0] TIMER_ADDR_USE  = 32'h0000_0400;
  localparam logic [31:0] TIMER_ADDR_MASK = 32'hFFFF_FFF8;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  typedef struct packed {
    wr_state_e wr;
    rd_state_e rd;
  } fsm_state_t;

  // Bits 0..n_ext of PEND/MASK exist: timer plus one per external input.
  function automatic logic [31:0] irq_valid_mask(input int n_ext);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i <= n_ext) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous level input, followed by a
// rising-edge detector on the synchronized signal.
module irq_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic rise
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/axi_timer_irq.sv
// AXI4-lite slave: 32-bit down-counting timer plus interrupt pending/mask
// controller. Optional prescaler enabled by defining AXI_TIMER_PRESCALER_EN.
module axi_timer_irq
  import axi_timer_irq_pkg::*;
#(
  parameter int N_EXT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [31:0]      axi_awaddr,
  input  logic [2:0]       axi_awprot,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  input  logic [31:0]      axi_wdata,
  input  logic [3:0]       axi_wstrb,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  input  logic [31:0]      axi_araddr,
  input  logic [2:0]       axi_arprot,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [31:0]      axi_rdata,
  input  logic [N_EXT-1:0] ext_irq,
  output logic [31:0]      irq_out
);

  localparam logic [31:0] VALID = irq_valid_mask(N_EXT);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; AW and W are only ever accepted together, B/R held until ready.
  fsm_state_t fsm_q, fsm_d;
  logic       wr_accept, rd_accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) fsm_q <= '{wr: WR_IDLE, rd: RD_IDLE};
    else      fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d      = fsm_q;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    axi_bvalid = 1'b0;
    axi_rvalid = 1'b0;
    case (fsm_q.wr)
      WR_IDLE: if (axi_awvalid && axi_wvalid) begin
        wr_accept = 1'b1;
        fsm_d.wr  = WR_RESP;
      end
      WR_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) fsm_d.wr = WR_IDLE;
      end
      default: fsm_d.wr = WR_IDLE;
    endcase
    case (fsm_q.rd)
      RD_IDLE: if (axi_arvalid) begin
        rd_accept = 1'b1;
        fsm_d.rd  = RD_DATA;
      end
      RD_DATA: begin
        axi_rvalid = 1'b1;
        if (axi_rready) fsm_d.rd = RD_IDLE;
      end
      default: fsm_d.rd = RD_IDLE;
    endcase
  end

  assign axi_awready = wr_accept;
  assign axi_wready  = wr_accept;
  assign axi_arready = rd_accept;

  logic [ADDR_DEC_W-1:0] wr_addr;
  logic [31:0]           wmask;
  logic                  wr_ctrl, wr_load, wr_pend, wr_mask;

  assign wr_addr = axi_awaddr[ADDR_DEC_W-1:0];
  assign wmask   = strb_mask(axi_wstrb);
  assign wr_ctrl = wr_accept && (wr_addr == TIMER_CTRL);
  assign wr_load = wr_accept && (wr_addr == TIMER_LOAD);
  assign wr_pend = wr_accept && (wr_addr == TIMER_PEND);
  assign wr_mask = wr_accept && (wr_addr == TIMER_MASK);

  logic        ctrl_en, ctrl_reload;
  logic [31:0] load_q, count_q, pend_q, mask_q;
  logic [31:0] load_new, pend_set, pend_clr;
  logic [N_EXT-1:0] ext_rise;
  logic        tick, tmr_step, count_zero;

  for (genvar k = 0; k < N_EXT; k++) begin : g_sync
    irq_sync_edge u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (ext_irq[k]),
      .rise     (ext_rise[k])
    );
  end

`ifdef AXI_TIMER_PRESCALER_EN
  logic [7:0] presc_q, psc_cnt;
  logic       wr_presc;

  assign wr_presc = wr_accept && (wr_addr == TIMER_PRESC);
  assign tick     = ctrl_en && (psc_cnt == presc_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr_presc && axi_wstrb[0]) presc_q <= axi_wdata[7:0];
      if (wr_ctrl || wr_load)  psc_cnt <= '0;
      else if (ctrl_en)        psc_cnt <= (psc_cnt == presc_q) ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick = ctrl_en;
`endif

  // A CTRL or LOAD write owns the timer state for that cycle.
  assign tmr_step   = tick && !(wr_ctrl || wr_load);
  assign count_zero = (count_q == '0);
  assign load_new   = (load_q & ~wmask) | (axi_wdata & wmask);
  assign pend_clr   = wr_pend ? (axi_wdata & wmask) : '0;

  always_comb begin
    pend_set          = '0;
    pend_set[0]       = tmr_step && count_zero;
    pend_set[N_EXT:1] = ext_rise;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      load_q      <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      irq_out     <= '0;
    end else begin
      if (wr_ctrl && axi_wstrb[0]) begin
        ctrl_en     <= axi_wdata[CTRL_EN];
        ctrl_reload <= axi_wdata[CTRL_RELOAD];
      end else if (tmr_step && count_zero && !ctrl_reload) begin
        ctrl_en <= 1'b0;
      end
      if (wr_load) begin
        load_q  <= load_new;
        count_q <= load_new;
      end else if (tmr_step) begin
        count_q <= count_zero ? (ctrl_reload ? load_q : '0) : count_q - 32'd1;
      end
      if (wr_mask) mask_q <= ((mask_q & ~wmask) | (axi_wdata & wmask)) & VALID;
      // Set terms are OR-ed after the clear so a same-cycle set wins.
      pend_q  <= ((pend_q & ~pend_clr) | pend_set) & VALID;
      irq_out <= pend_q & mask_q;
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (axi_araddr[ADDR_DEC_W-1:0])
      TIMER_CTRL:  rd_word = {30'd0, ctrl_reload, ctrl_en};
      TIMER_LOAD:  rd_word = load_q;
      TIMER_COUNT: rd_word = count_q;
      TIMER_PEND:  rd_word = pend_q;
      TIMER_MASK:  rd_word = mask_q;
`ifdef AXI_TIMER_PRESCALER_EN
      TIMER_PRESC: rd_word = {24'd0, presc_q};
`endif
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           axi_rdata <= '0;
    else if (rd_accept) axi_rdata <= rd_word;
  end

  logic unused_ok;
  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[31:ADDR_DEC_W],
                       axi_araddr[31:ADDR_DEC_W]};

endmodule

// File: tb/tb_axi_timer_irq.sv
// Directed self-checking bench for axi_timer_irq (default build, N_EXT=4).
module tb_axi_timer_irq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_bready = 1'b0;
  logic        axi_arvalid = 1'b0, axi_rready = 1'b0;
  logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
  logic [31:0] axi_awaddr = '0, axi_wdata = '0, axi_araddr = '0;
  logic [2:0]  axi_awprot = '0, axi_arprot = '0;
  logic [3:0]  axi_wstrb = '0;
  logic [31:0] axi_rdata, irq_out;
  logic [3:0]  ext_irq = '0;

  int n_checks = 0;
  int errors   = 0;

  axi_timer_irq #(.N_EXT(4)) dut (
    .CLK(CLK), .RST(RST),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .ext_irq(ext_irq), .irq_out(irq_out)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Starts #1 after an edge; accept on the next edge, B handshake one edge later.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    axi_awaddr  = {29'd0, a};
    axi_wdata   = d;
    axi_wstrb   = s;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    axi_bready  = 1'b1;
    #1;
    n = 0;
    while (!(axi_awready && axi_wready) && n < 20) begin tick(1); n++; end
    check_eq("wr_accept", {31'd0, axi_awready & axi_wready}, 32'd1);
    tick(1);
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    n = 0;
    while (!axi_bvalid && n < 20) begin tick(1); n++; end
    check_eq("wr_bvalid", {31'd0, axi_bvalid}, 32'd1);
    tick(1);
    axi_bready = 1'b0;
  endtask

  // Starts #1 after an edge; rdata captured on the next edge.
  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    int n;
    axi_araddr  = {29'd0, a};
    axi_arvalid = 1'b1;
    axi_rready  = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < 20) begin tick(1); n++; end
    check_eq("rd_accept", {31'd0, axi_arready}, 32'd1);
    tick(1);
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 20) begin tick(1); n++; end
    check_eq(tag, axi_rdata, exp);
    tick(1);
    axi_rready = 1'b0;
  endtask

  initial begin
    tick(3);
    RST = 1'b1;
    tick(1);

    // reset state
    check_eq("rst_irq_out", irq_out, 32'd0);
    check_eq("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_word%0d", i), i[2:0], 32'd0);

    // auto-reload, LOAD=5
    wr(3'd4, 32'd1, 4'hF);
    wr(3'd1, 32'd5, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    rd_chk("reload_count_a", 3'd2, 32'd4);
    rd_chk("reload_count_b", 3'd2, 32'd2);
    rd_chk("reload_count_c", 3'd2, 32'd0);
    rd_chk("reload_count_d", 3'd2, 32'd4);
    check_eq("reload_irq", irq_out, 32'd1);
    wr(3'd3, 32'd1, 4'hF);
    rd_chk("reload_pend_clr", 3'd3, 32'd0);
    rd_chk("reload_pend_again", 3'd3, 32'd1);
    rd_chk("reload_count_e", 3'd2, 32'd2);
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    rd_chk("stop_pend", 3'd3, 32'd0);

    // one-shot, LOAD=3
    wr(3'd1, 32'd3, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    tick(10);
    rd_chk("oneshot_ctrl", 3'd0, 32'd0);
    rd_chk("oneshot_count", 3'd2, 32'd0);
    rd_chk("oneshot_pend", 3'd3, 32'd1);
    wr(3'd3, 32'd1, 4'hF);
    tick(10);
    rd_chk("oneshot_once", 3'd3, 32'd0);
    check_eq("oneshot_irq_clr", irq_out, 32'd0);

    // set beats W1C: LOAD=0 + RELOAD sets PEND[0] every cycle
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    wr(3'd3, 32'd1, 4'hF);
    check_eq("w1c_race_irq", irq_out, 32'd1);
    rd_chk("w1c_race_pend", 3'd3, 32'd1);
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    tick(2);
    check_eq("race_cleanup_irq", irq_out, 32'd0);

    // byte strobes, read-only and unused words
    wr(3'd1, 32'h1122_3344, 4'b0101);
    rd_chk("load_strb", 3'd1, 32'h0022_0044);
    rd_chk("load_copies_count", 3'd2, 32'h0022_0044);
    wr(3'd2, 32'd7, 4'hF);
    rd_chk("count_readonly", 3'd2, 32'h0022_0044);
    wr(3'd4, 32'hFFFF_FFFF, 4'hF);
    rd_chk("mask_limit", 3'd4, 32'h0000_001F);
    wr(3'd0, 32'hFFFF_FFFC, 4'hF);
    rd_chk("ctrl_unused_bits", 3'd0, 32'd0);
    wr(3'd5, 32'h0000_00FF, 4'hF);
    rd_chk("presc_absent", 3'd5, 32'd0);
    wr(3'd6, 32'h0000_1234, 4'hF);
    rd_chk("word6", 3'd6, 32'd0);
    rd_chk("word7", 3'd7, 32'd0);

    // external input 2 -> PEND bit 3, four edges to irq_out
    wr(3'd4, 32'h8, 4'hF);
    ext_irq[2] = 1'b1;
    tick(3);
    check_eq("ext_irq_edge3", irq_out, 32'd0);
    tick(1);
    check_eq("ext_irq_edge4", irq_out, 32'h8);
    rd_chk("ext_pend", 3'd3, 32'h8);
    wr(3'd3, 32'h8, 4'b1110);
    rd_chk("ext_pend_strb_off", 3'd3, 32'h8);
    wr(3'd3, 32'h8, 4'b0001);
    check_eq("ext_irq_cleared", irq_out, 32'd0);
    ext_irq[2] = 1'b0;
    tick(4);

    // populate state, then reset in the middle of a read
    wr(3'd1, 32'h55, 4'hF);
    wr(3'd4, 32'h1F, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    ext_irq[0] = 1'b1;
    tick(5);
    ext_irq[0] = 1'b0;
    tick(3);
    check_eq("pre_rst_irq", irq_out & 32'h2, 32'h2);
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("aw_alone", {30'd0, axi_awready, axi_wready}, 32'd0);
    end
    axi_awvalid = 1'b0;
    axi_araddr  = 32'd1;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b0;
    tick(1);
    axi_arvalid = 1'b0;
    check_eq("pre_rst_rvalid", {31'd0, axi_rvalid}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_eq("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check_eq("rst_rdata", axi_rdata, 32'd0);
    check_eq("rst_irq_mid", irq_out, 32'd0);
    tick(2);
    RST = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("post_rst_word%0d", i), i[2:0], 32'd0);
    check_eq("post_rst_irq", irq_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
